du_state_dumper: RTL and testbench
==================================

DU_STATE_DUMPER -- requirements
Module: du_state_dumper

Interface
REQ-001 SHALL have parameter NB_REG, default 32, width of register and memory data words.
REQ-002 SHALL have parameter NB_R_INT, default 341, width of the concatenated pipeline-latch snapshot.
REQ-003 SHALL have parameter N_REGS, default 32, number of register-file entries dumped.
REQ-004 SHALL have parameter N_MEM_WORDS, default 64, number of data-memory words dumped.
REQ-005 SHALL have parameter RD_LAT, default 2, cycles from address change to sampling the read data.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: i_clk  in  1  rising-edge clock; i_reset  in  1  asynchronous active-low reset.
REQ-007 SHALL have i_start  in  1  single-cycle dump request.
REQ-008 SHALL have i_reg_data  in  NB_REG  register-file read data for o_reg_addr.
REQ-009 SHALL have i_mem_data  in  NB_REG  data-memory read data for o_mem_addr.
REQ-010 SHALL have i_latch_data  in  NB_R_INT  concatenated IF/ID, ID/EX, EX/M, M/WB latch contents.
REQ-011 SHALL have i_tx_done  in  1  single-cycle pulse from the UART transmitter when a byte has been sent.
REQ-012 SHALL have o_tx_data  out  8  byte to transmit; o_tx_start  out  1  single-cycle transmit request.
REQ-013 SHALL have o_reg_addr  out  5  register select; o_mem_addr  out  8  data-memory byte address.
REQ-014 SHALL have o_busy  out  1  dump in progress; o_done  out  1  single-cycle pulse at dump end.

Function
REQ-015 SHALL send one frame per accepted i_start: 0xA5 header, N_REGS words, N_MEM_WORDS words, ceil(NB_R_INT/8) latch bytes, one checksum byte (429 bytes at defaults).
REQ-016 SHALL send every word as 4 bytes, least significant byte first.
REQ-017 SHALL capture i_latch_data into an internal register in the cycle i_start is accepted, zero-extended to 344 bits, and send it LSB byte first.
REQ-018 SHALL drive o_reg_addr = k for register k, and o_mem_addr = 4*m (modulo 256) for memory word m.
REQ-019 SHALL hold each address for RD_LAT cycles before sampling the corresponding read data into a 32-bit shift register.
REQ-020 SHALL compute the checksum as the XOR of all bytes after the header, excluding the checksum byte itself.
REQ-021 SHALL use states IDLE, HDR, SET_ADDR, WAIT_RD, SEND, WAIT_TX, LATCH, CSUM, DONE.
REQ-022 SHALL assert o_tx_start for exactly one cycle on entering SEND, with o_tx_data stable from that cycle until i_tx_done.
REQ-023 SHALL stay in WAIT_TX until i_tx_done, then advance to the next byte; no new o_tx_start before i_tx_done.
REQ-024 SHALL ignore i_tx_done outside WAIT_TX.
REQ-025 SHALL ignore i_start while o_busy=1.
REQ-026 SHALL assert o_busy from the cycle after i_start through the DONE cycle, pulse o_done in DONE, and return to IDLE next cycle.
REQ-027 SHALL use a byte counter (0..3) per word and a word counter that wraps to 0 when moving from the register to the memory section.

Reset
REQ-028 SHALL, on i_reset=0 at any time including mid-frame, force IDLE and set o_tx_start=0, o_tx_data=0x00, o_reg_addr=0, o_mem_addr=0, o_busy=0, o_done=0, and clear the checksum, counters and snapshot.
REQ-029 SHALL NOT resume an aborted frame after reset release; a new i_start is required.

Structure
REQ-030 SHALL place the header constant 0xA5, the state encoding and the frame byte counts in the shared debug-unit package.
REQ-031 SHALL be built as one FSM module plus one sub-module, du_word_serializer (word load, byte shift, byte index).

Verification
REQ-032 Reset then i_start, model returning i_tx_done 10 cycles after each o_tx_start -> exactly 429 o_tx_start pulses, first byte 0xA5, then o_done once.
REQ-033 Register file k = 0x11223300+k -> bytes 1..4 are 00 33 22 11, and bytes 125..128 are 1F 33 22 11.
REQ-034 Memory word m = 0xDEAD0000|m -> o_mem_addr sequence 0,4,...,252; bytes for word 63 are 3F 00 AD DE.
REQ-035 i_latch_data bit 340 = 1, all other bits 0 -> last latch byte 0x10, all other latch bytes 0x00; checksum equals XOR of payload.
REQ-036 Extra i_start pulses and stray i_tx_done pulses mid-frame -> frame unchanged, no second frame.
REQ-037 i_reset low during register word 5 -> all outputs at reset values; a new i_start yields a complete 429-byte frame.

Source files
------------

// File: rtl/du_state_dumper_pkg.sv
// Shared debug-unit definitions: frame constants, FSM encoding, section codes.
package du_state_dumper_pkg;

  localparam logic [7:0] HDR_BYTE   = 8'hA5;
  localparam int         WORD_BYTES = 4;

  // Bytes needed to carry a field of the given bit width.
  function automatic int ceil_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

  // Frame layout at the default parameterisation.
  localparam int DEF_N_REGS      = 32;
  localparam int DEF_N_MEM_WORDS = 64;
  localparam int DEF_NB_R_INT    = 341;
  localparam int DEF_LATCH_BYTES = ceil_bytes(DEF_NB_R_INT);
  localparam int DEF_FRAME_BYTES = 1 + WORD_BYTES * (DEF_N_REGS + DEF_N_MEM_WORDS)
                                   + DEF_LATCH_BYTES + 1;

  // FSM state encoding.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_HDR      = 4'd1;
  localparam logic [3:0] ST_SET_ADDR = 4'd2;
  localparam logic [3:0] ST_WAIT_RD  = 4'd3;
  localparam logic [3:0] ST_SEND     = 4'd4;
  localparam logic [3:0] ST_WAIT_TX  = 4'd5;
  localparam logic [3:0] ST_LATCH    = 4'd6;
  localparam logic [3:0] ST_CSUM     = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  // Which part of the frame the byte in flight belongs to.
  localparam logic [2:0] SEC_HDR   = 3'd0;
  localparam logic [2:0] SEC_REG   = 3'd1;
  localparam logic [2:0] SEC_MEM   = 3'd2;
  localparam logic [2:0] SEC_LATCH = 3'd3;
  localparam logic [2:0] SEC_CSUM  = 3'd4;

endpackage

// File: rtl/du_word_serializer.sv
// Holds one sampled data word and hands it out a byte at a time, LSB first.
module du_word_serializer #(
  parameter int NB_REG = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [NB_REG-1:0] i_word,
  output logic [7:0]        o_next_byte,
  output logic              o_last
);

  localparam int BPW = NB_REG / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [NB_REG-1:0] shreg;
  logic [IW-1:0]     byte_idx;

  // The byte after the one currently on the wire.
  assign o_next_byte = shreg[15:8];
  assign o_last      = (byte_idx == IW'(BPW - 1));

  // Load resets the byte index; each shift exposes the next byte.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (i_clear) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (i_load) begin
      shreg    <= i_word;
      byte_idx <= '0;
    end else if (i_shift) begin
      shreg    <= shreg >> 8;
      byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/du_state_dumper.sv
// Streams a debug frame (header, register file, data memory, pipeline latch
// snapshot, XOR checksum) to a byte-wide UART transmitter.
module du_state_dumper
  import du_state_dumper_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_R_INT    = 341,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 64,
  parameter int RD_LAT      = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_REG-1:0]   i_reg_data,
  input  logic [NB_REG-1:0]   i_mem_data,
  input  logic [NB_R_INT-1:0] i_latch_data,
  input  logic                i_tx_done,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic [4:0]          o_reg_addr,
  output logic [7:0]          o_mem_addr,
  output logic                o_busy,
  output logic                o_done
);

  localparam int LATCH_BYTES = ceil_bytes(NB_R_INT);
  localparam int LATCH_W     = 8 * LATCH_BYTES;

  logic [3:0]         state;
  logic [2:0]         sec;
  logic [15:0]        word_cnt;
  logic [15:0]        lat_cnt;
  logic [7:0]         rd_cnt;
  logic [7:0]         csum;
  logic [LATCH_W-1:0] snap;

  logic              rd_done;
  logic              tx_ack;
  logic              word_sec;
  logic              ser_clear, ser_load, ser_shift, ser_last;
  logic [7:0]        ser_next;
  logic [NB_REG-1:0] rd_word;

  assign rd_done  = (rd_cnt == 8'(RD_LAT - 1));
  assign tx_ack   = (state == ST_WAIT_TX) && i_tx_done;
  assign word_sec = (sec == SEC_REG) || (sec == SEC_MEM);
  assign rd_word  = (sec == SEC_MEM) ? i_mem_data : i_reg_data;

  assign ser_clear = (state == ST_IDLE) && i_start;
  assign ser_load  = (state == ST_WAIT_RD) && rd_done;
  assign ser_shift = tx_ack && word_sec && !ser_last;

  assign o_tx_start = (state == ST_SEND);
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE);

  du_word_serializer #(.NB_REG(NB_REG)) u_ser (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (ser_clear),
    .i_load      (ser_load),
    .i_shift     (ser_shift),
    .i_word      (rd_word),
    .o_next_byte (ser_next),
    .o_last      (ser_last)
  );

  // Frame sequencer: every byte goes SEND -> WAIT_TX, the section decides
  // where to fetch the next one from.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      sec        <= SEC_HDR;
      word_cnt   <= '0;
      lat_cnt    <= '0;
      rd_cnt     <= '0;
      csum       <= '0;
      snap       <= '0;
      o_tx_data  <= '0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_start) begin
          snap     <= LATCH_W'(i_latch_data);
          csum     <= '0;
          word_cnt <= '0;
          lat_cnt  <= '0;
          state    <= ST_HDR;
        end
        ST_HDR: begin
          o_tx_data <= HDR_BYTE;
          sec       <= SEC_HDR;
          state     <= ST_SEND;
        end
        ST_SET_ADDR: begin
          if (sec == SEC_REG) o_reg_addr <= word_cnt[4:0];
          else                o_mem_addr <= {word_cnt[5:0], 2'b00};
          rd_cnt <= '0;
          state  <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (rd_done) begin
            o_tx_data <= rd_word[7:0];
            state     <= ST_SEND;
          end else begin
            rd_cnt <= rd_cnt + 8'd1;
          end
        end
        ST_SEND: state <= ST_WAIT_TX;
        ST_WAIT_TX: if (i_tx_done) begin
          // Only payload bytes feed the checksum.
          if (sec != SEC_HDR && sec != SEC_CSUM) csum <= csum ^ o_tx_data;
          case (sec)
            SEC_HDR: begin
              sec      <= SEC_REG;
              word_cnt <= '0;
              state    <= ST_SET_ADDR;
            end
            SEC_REG, SEC_MEM: begin
              if (!ser_last) begin
                o_tx_data <= ser_next;
                state     <= ST_SEND;
              end else if (sec == SEC_REG && word_cnt == 16'(N_REGS - 1)) begin
                sec      <= SEC_MEM;
                word_cnt <= '0;
                state    <= ST_SET_ADDR;
              end else if (sec == SEC_MEM && word_cnt == 16'(N_MEM_WORDS - 1)) begin
                sec     <= SEC_LATCH;
                lat_cnt <= '0;
                state   <= ST_LATCH;
              end else begin
                word_cnt <= word_cnt + 16'd1;
                state    <= ST_SET_ADDR;
              end
            end
            SEC_LATCH: begin
              if (lat_cnt == 16'(LATCH_BYTES - 1)) begin
                state <= ST_CSUM;
              end else begin
                lat_cnt <= lat_cnt + 16'd1;
                state   <= ST_LATCH;
              end
            end
            default: state <= ST_DONE;
          endcase
        end
        ST_LATCH: begin
          o_tx_data <= snap[7:0];
          snap      <= snap >> 8;
          state     <= ST_SEND;
        end
        ST_CSUM: begin
          o_tx_data <= csum;
          sec       <= SEC_CSUM;
          state     <= ST_SEND;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_du_state_dumper.sv
// Bench for du_state_dumper: UART responder, synchronous memory models and a
// frame-level reference built from the data contents.
module tb_du_state_dumper;

  localparam int FRAME       = 429;
  localparam int LATCH_BYTES = 43;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_start = 1'b0;
  logic [31:0]  i_reg_data, i_mem_data;
  logic [340:0] i_latch_data = '0;
  logic         i_tx_done;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic [4:0]   o_reg_addr;
  logic [7:0]   o_mem_addr;
  logic         o_busy, o_done;

  logic model_done = 1'b0, stray_done = 1'b0;
  assign i_tx_done = model_done | stray_done;

  always #5 i_clk = ~i_clk;

  du_state_dumper dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_reg_data(i_reg_data), .i_mem_data(i_mem_data),
    .i_latch_data(i_latch_data), .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_reg_addr(o_reg_addr), .o_mem_addr(o_mem_addr),
    .o_busy(o_busy), .o_done(o_done)
  );

  logic [31:0] regs [32];
  logic [31:0] mem  [64];

  // Synchronous read ports: data appears one cycle after the address.
  always @(posedge i_clk) begin
    i_reg_data <= regs[o_reg_addr];
    i_mem_data <= (o_mem_addr[1:0] == 2'b00) ? mem[o_mem_addr[7:2]] : 32'hBAD0BAD0;
  end

  int total = 0, bad = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  int  done_cnt, proto_err, stable_err;
  bit  stray_en = 1'b0;
  bit  busy_after_start;

  // UART responder: done pulse 10 cycles after each start, checks the byte
  // stays put and that no start arrives while one is outstanding.
  initial begin
    bit         pend = 1'b0;
    int         cd = 0;
    logic [7:0] pend_byte = '0;
    forever begin
      @(negedge i_clk);
      model_done = 1'b0;
      stray_done = 1'b0;
      if (!i_reset) begin
        pend = 1'b0;
        cd   = 0;
      end else begin
        if (pend) begin
          if (o_tx_data !== pend_byte) stable_err++;
          cd--;
          if (cd == 0) begin
            model_done = 1'b1;
            pend       = 1'b0;
          end
        end
        if (o_tx_start) begin
          if (pend) proto_err++;
          rx.push_back(o_tx_data);
          pend      = 1'b1;
          pend_byte = o_tx_data;
          cd        = 10;
          if (stray_en) stray_done = 1'b1;
        end
        if (o_done) done_cnt++;
      end
    end
  end

  // Reference frame from the current register/memory/latch contents.
  task automatic build_exp();
    logic [7:0]   cs = 8'h00;
    logic [343:0] lat = '0;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 32; k++)
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(regs[k][8*b +: 8]);
        cs ^= regs[k][8*b +: 8];
      end
    for (int m = 0; m < 64; m++)
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(mem[m][8*b +: 8]);
        cs ^= mem[m][8*b +: 8];
      end
    lat[340:0] = i_latch_data;
    for (int i = 0; i < LATCH_BYTES; i++) begin
      exp_q.push_back(lat[8*i +: 8]);
      cs ^= lat[8*i +: 8];
    end
    exp_q.push_back(cs);
  endtask

  function automatic int frame_diffs();
    int n = 0;
    for (int i = 0; i < FRAME; i++)
      if (rx[i] !== exp_q[i]) begin
        if (n == 0) $display("  first diff at byte %0d: got %h want %h", i, rx[i], exp_q[i]);
        n++;
      end
    return n;
  endfunction

  task automatic randomize_data();
    logic [351:0] t;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    for (int m = 0; m < 64; m++) mem[m] = $urandom;
    for (int w = 0; w < 11; w++) t[32*w +: 32] = $urandom;
    i_latch_data = t[340:0];
  endtask

  // Issue one start and wait (bounded) for o_done; latch input is scrambled
  // after acceptance so only the captured snapshot can produce the right bytes.
  task automatic run_frame(input bit extra, output bit ok, output int nbytes);
    rx = {};
    done_cnt = 0; proto_err = 0; stable_err = 0;
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    busy_after_start = o_busy;
    i_latch_data = ~i_latch_data;
    ok = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      @(negedge i_clk);
      if (o_done) begin ok = 1'b1; i_start = 1'b0; break; end
      i_start = extra && (c % 97 == 3);
    end
    i_start = 1'b0;
    repeat (30) @(negedge i_clk);
    i_latch_data = ~i_latch_data;
    nbytes = rx.size();
    while (rx.size() < FRAME) rx.push_back(8'hxx);
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    total++;
    if ({o_tx_start, o_tx_data, o_reg_addr, o_mem_addr, o_busy, o_done} !== 24'h0) begin
      bad++; $display("FAIL reset_outs got %h want 000000",
        {o_tx_start, o_tx_data, o_reg_addr, o_mem_addr, o_busy, o_done});
    end
    i_reset = 1'b1;
    repeat (5) @(negedge i_clk);
    total++;
    if (o_busy !== 1'b0 || rx.size() != 0) begin
      bad++; $display("FAIL idle_after_reset busy=%b bytes=%0d want 0/0", o_busy, rx.size());
    end
  endtask

  task automatic test_directed();
    bit ok; int nb; int nd; logic [7:0] x = 8'h00; logic [7:0] lor = 8'h00;
    for (int k = 0; k < 32; k++) regs[k] = 32'h11223300 + k;
    for (int m = 0; m < 64; m++) mem[m] = 32'hDEAD0000 | m;
    i_latch_data = '0;
    i_latch_data[340] = 1'b1;
    build_exp();
    run_frame(1'b0, ok, nb);
    total++; if (!ok) begin bad++; $display("FAIL dir_timeout no o_done within bound"); end
    total++; if (busy_after_start !== 1'b1) begin bad++; $display("FAIL dir_busy got %b want 1", busy_after_start); end
    total++; if (nb != FRAME) begin bad++; $display("FAIL dir_bytes got %0d want %0d", nb, FRAME); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL dir_done got %0d want 1", done_cnt); end
    total++; if (rx[0] !== 8'hA5) begin bad++; $display("FAIL dir_hdr got %h want a5", rx[0]); end
    total++; if ({rx[4], rx[3], rx[2], rx[1]} !== 32'h11223300) begin
      bad++; $display("FAIL dir_reg0 got %h want 11223300", {rx[4], rx[3], rx[2], rx[1]}); end
    total++; if ({rx[128], rx[127], rx[126], rx[125]} !== 32'h1122331F) begin
      bad++; $display("FAIL dir_reg31 got %h want 1122331f", {rx[128], rx[127], rx[126], rx[125]}); end
    total++; if ({rx[384], rx[383], rx[382], rx[381]} !== 32'hDEAD003F) begin
      bad++; $display("FAIL dir_mem63 got %h want dead003f", {rx[384], rx[383], rx[382], rx[381]}); end
    for (int i = 385; i < 427; i++) lor |= rx[i];
    total++; if (lor !== 8'h00 || rx[427] !== 8'h10) begin
      bad++; $display("FAIL dir_latch or_low=%h last=%h want 00/10", lor, rx[427]); end
    for (int i = 1; i < 428; i++) x ^= rx[i];
    total++; if (rx[428] !== x) begin bad++; $display("FAIL dir_csum got %h want %h", rx[428], x); end
    nd = frame_diffs();
    total++; if (nd != 0) begin bad++; $display("FAIL dir_frame diffs=%0d want 0", nd); end
    total++; if (proto_err != 0 || stable_err != 0) begin
      bad++; $display("FAIL dir_handshake proto=%0d stable=%0d want 0/0", proto_err, stable_err); end
  endtask

  task automatic test_random();
    bit ok; int nb; int nd;
    for (int r = 0; r < 2; r++) begin
      randomize_data();
      build_exp();
      run_frame(1'b0, ok, nb);
      nd = frame_diffs();
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_timeout no o_done", r); end
      total++; if (nb != FRAME) begin bad++; $display("FAIL rnd%0d_bytes got %0d want %0d", r, nb, FRAME); end
      total++; if (nd != 0) begin bad++; $display("FAIL rnd%0d_frame diffs=%0d want 0", r, nd); end
      total++; if (done_cnt != 1 || o_busy !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_end done=%0d busy=%b want 1/0", r, done_cnt, o_busy); end
      total++; if (proto_err != 0 || stable_err != 0) begin
        bad++; $display("FAIL rnd%0d_handshake proto=%0d stable=%0d want 0/0", r, proto_err, stable_err); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int nb; int nd;
    randomize_data();
    build_exp();
    stray_en = 1'b1;
    run_frame(1'b1, ok, nb);
    stray_en = 1'b0;
    nd = frame_diffs();
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout no o_done"); end
    total++; if (nb != FRAME) begin bad++; $display("FAIL b2b_bytes got %0d want %0d", nb, FRAME); end
    total++; if (nd != 0) begin bad++; $display("FAIL b2b_frame diffs=%0d want 0", nd); end
    total++; if (done_cnt != 1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_single done=%0d busy=%b want 1/0", done_cnt, o_busy); end
    total++; if (proto_err != 0 || stable_err != 0) begin
      bad++; $display("FAIL b2b_handshake proto=%0d stable=%0d want 0/0", proto_err, stable_err); end
  endtask

  task automatic test_reset_midframe();
    bit ok = 1'b0; int nb; int nd; int held;
    randomize_data();
    rx = {};
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    // Wait until the first byte of register word 5 is on the wire.
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      if (rx.size() >= 22) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout bytes=%0d want 22", rx.size()); end
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    total++;
    if ({o_tx_start, o_tx_data, o_reg_addr, o_mem_addr, o_busy, o_done} !== 24'h0) begin
      bad++; $display("FAIL mid_reset_outs got %h want 000000",
        {o_tx_start, o_tx_data, o_reg_addr, o_mem_addr, o_busy, o_done});
    end
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    held = rx.size();
    repeat (50) @(negedge i_clk);
    total++; if (o_busy !== 1'b0 || rx.size() != held) begin
      bad++; $display("FAIL mid_no_resume busy=%b new_bytes=%0d want 0/0", o_busy, rx.size() - held); end
    build_exp();
    run_frame(1'b0, ok, nb);
    nd = frame_diffs();
    total++; if (!ok || nb != FRAME) begin
      bad++; $display("FAIL mid_refresh done=%b bytes=%0d want 1/%0d", ok, nb, FRAME); end
    total++; if (nd != 0) begin bad++; $display("FAIL mid_frame diffs=%0d want 0", nd); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = '0;
    for (int m = 0; m < 64; m++) mem[m] = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
